mux_key: RTL and testbench



---
 rtl/mux_key_pkg.sv | 9 +
 rtl/mux_key_core.sv | 41 ++++
 rtl/mux_key.sv | 64 ++++++
 tb/tb_mux_key.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mux_key_pkg.sv
// Shared defaults for the key->data lookup mux.
package mux_key_pkg;

  localparam int DEF_NR_KEY   = 6;
  localparam int DEF_KEY_LEN  = 3;
  localparam int DEF_DATA_LEN = 2;
  localparam int DEF_REG_OUT  = 0;

endpackage : mux_key_pkg

// File: rtl/mux_key_core.sv
// Combinational priority search over a packed {key,data} table; lowest index wins.
module mux_key_core
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = DEF_NR_KEY,
  parameter int KEY_LEN  = DEF_KEY_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  sel_data,
  output logic                                 sel_hit
);

  localparam int PAIR = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  tbl_key_s  [NR_KEY];
  logic [DATA_LEN-1:0] tbl_data_s [NR_KEY];

  for (genvar i = 0; i < NR_KEY; i++) begin : g_tbl
    assign tbl_key_s[i]  = lut[(NR_KEY-i)*PAIR-1 -: KEY_LEN];
    assign tbl_data_s[i] = lut[(NR_KEY-i)*PAIR-KEY_LEN-1 -: DATA_LEN];
  end

  // Walk from the highest index down so the lowest matching entry is the last
  // to write; an X/Z key makes the compare non-true and so never matches.
  always_comb begin
    sel_data = {DATA_LEN{1'b0}};
    sel_hit  = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (tbl_key_s[i] == key) begin
        sel_data = tbl_data_s[i];
        sel_hit  = 1'b1;
      end else begin
        sel_data = sel_data;
        sel_hit  = sel_hit;
      end
    end
  end

endmodule : mux_key_core

// File: rtl/mux_key.sv
// Key->data lookup mux with an optional one-cycle output register.
module mux_key
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = DEF_NR_KEY,
  parameter int KEY_LEN  = DEF_KEY_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int REG_OUT  = DEF_REG_OUT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit
);

  if (NR_KEY < 1 || KEY_LEN < 1 || DATA_LEN < 1) begin : g_bad_size
    $error("mux_key: NR_KEY, KEY_LEN and DATA_LEN must each be >= 1");
  end
  if (REG_OUT != 0 && REG_OUT != 1) begin : g_bad_reg
    $error("mux_key: REG_OUT must be 0 or 1");
  end

  logic [DATA_LEN-1:0] sel_data_s;
  logic                sel_hit_s;

  mux_key_core #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_core (
    .key      (key),
    .lut      (lut),
    .sel_data (sel_data_s),
    .sel_hit  (sel_hit_s)
  );

  if (REG_OUT == 1) begin : g_reg
    logic [DATA_LEN-1:0] out_q;
    logic                hit_q;

    // Output register; reset clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= {DATA_LEN{1'b0}};
        hit_q <= 1'b0;
      end else begin
        out_q <= sel_data_s;
        hit_q <= sel_hit_s;
      end
    end

    assign out = out_q;
    assign hit = hit_q;
  end else begin : g_comb
    // Clock and reset have no role in the combinational configuration.
    logic unused_s;
    assign unused_s = clk ^ rst_n;
    assign out      = sel_data_s;
    assign hit      = sel_hit_s;
  end

endmodule : mux_key

// File: tb/tb_mux_key.sv
// Directed self-checking bench for mux_key: combinational, registered and 1-entry configs.
module tb_mux_key;

  localparam logic [29:0] LUT_BASE = {3'b000, 2'b00, 3'b001, 2'b10, 3'b100, 2'b01,
                                      3'b101, 2'b11, 3'b110, 2'b10, 3'b111, 2'b01};
  localparam logic [29:0] LUT_DUP  = {3'b001, 2'b11, 3'b001, 2'b10, 3'b100, 2'b01,
                                      3'b101, 2'b11, 3'b110, 2'b10, 3'b111, 2'b01};

  logic        clk;
  logic        rst_n;
  logic [2:0]  key_c, key_r;
  logic [29:0] lut_c, lut_r;
  logic [1:0]  out_c, out_r;
  logic        hit_c, hit_r;
  logic [0:0]  key_e;
  logic [8:0]  lut_e;
  logic [7:0]  out_e;
  logic        hit_e;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  key;
    logic [29:0] lut;
    logic        rst_n;
    logic [1:0]  exp_out;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [11];

  mux_key #(.NR_KEY(6), .KEY_LEN(3), .DATA_LEN(2), .REG_OUT(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .key(key_c), .lut(lut_c), .out(out_c), .hit(hit_c));

  mux_key #(.NR_KEY(6), .KEY_LEN(3), .DATA_LEN(2), .REG_OUT(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .key(key_r), .lut(lut_r), .out(out_r), .hit(hit_r));

  mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(8), .REG_OUT(0)) u_edge (
    .clk(clk), .rst_n(rst_n), .key(key_e), .lut(lut_e), .out(out_e), .hit(hit_e));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{3'b000, LUT_BASE, 1'b1, 2'b00, 1'b1};
    vecs[1]  = '{3'b001, LUT_BASE, 1'b1, 2'b10, 1'b1};
    vecs[2]  = '{3'b100, LUT_BASE, 1'b1, 2'b01, 1'b1};
    vecs[3]  = '{3'b101, LUT_BASE, 1'b1, 2'b11, 1'b1};
    vecs[4]  = '{3'b110, LUT_BASE, 1'b1, 2'b10, 1'b1};
    vecs[5]  = '{3'b111, LUT_BASE, 1'b1, 2'b01, 1'b1};
    vecs[6]  = '{3'b010, LUT_BASE, 1'b1, 2'b00, 1'b0};
    vecs[7]  = '{3'b011, LUT_BASE, 1'b1, 2'b00, 1'b0};
    vecs[8]  = '{3'b001, LUT_DUP,  1'b1, 2'b11, 1'b1};
    vecs[9]  = '{3'b100, LUT_DUP,  1'b1, 2'b01, 1'b1};
    vecs[10] = '{3'b101, LUT_BASE, 1'b0, 2'b11, 1'b1};

    rst_n = 1'b0;
    key_c = 3'b000; lut_c = LUT_BASE;
    key_r = 3'b000; lut_r = LUT_BASE;
    key_e = 1'b0;   lut_e = {1'b1, 8'hA5};

    // combinational table
    for (int i = 0; i < 11; i++) begin
      rst_n = vecs[i].rst_n;
      key_c = vecs[i].key;
      lut_c = vecs[i].lut;
      #1;
      check($sformatf("comb_out[%0d]", i), {6'd0, out_c}, {6'd0, vecs[i].exp_out});
      check($sformatf("comb_hit[%0d]", i), {7'd0, hit_c}, {7'd0, vecs[i].exp_hit});
    end

    // registered: reset state, then latency
    rst_n = 1'b0;
    key_r = 3'b101;
    @(posedge clk); #1;
    check("reg_reset_out", {6'd0, out_r}, 8'h00);
    check("reg_reset_hit", {7'd0, hit_r}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    key_r = 3'b101;
    #1;
    check("reg_before_edge_out", {6'd0, out_r}, 8'h00);
    @(posedge clk); #1;
    check("reg_after_edge_out", {6'd0, out_r}, 8'h03);
    check("reg_after_edge_hit", {7'd0, hit_r}, 8'h01);
    @(negedge clk);
    key_r = 3'b010;
    #1;
    check("reg_hold_out", {6'd0, out_r}, 8'h03);
    @(posedge clk); #1;
    check("reg_miss_out", {6'd0, out_r}, 8'h00);
    check("reg_miss_hit", {7'd0, hit_r}, 8'h00);

    // async reset mid-cycle
    @(negedge clk);
    key_r = 3'b101;
    @(posedge clk); #1;
    check("reg_preset_out", {6'd0, out_r}, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    check("reg_async_out", {6'd0, out_r}, 8'h00);
    check("reg_async_hit", {7'd0, hit_r}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    key_r = 3'b001;
    #1;
    check("reg_post_rst_before", {6'd0, out_r}, 8'h00);
    @(posedge clk); #1;
    check("reg_post_rst_out", {6'd0, out_r}, 8'h02);
    check("reg_post_rst_hit", {7'd0, hit_r}, 8'h01);

    // single-entry config
    key_e = 1'b1;
    #1;
    check("edge_k1_out", out_e, 8'hA5);
    check("edge_k1_hit", {7'd0, hit_e}, 8'h01);
    key_e = 1'b0;
    #1;
    check("edge_k0_out", out_e, 8'h00);
    check("edge_k0_hit", {7'd0, hit_e}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_key
